// File: rtl/smg_scan_counter.sv
// ============================================================================
//  Module   : smg_scan_counter
//  Purpose  : BCD up/down counter with a multiplexed 7-segment scan driver,
//             count-tick prescaler and heartbeat LED.
//  Options  : define SMG_ZERO_BLANK_EN to blank leading-zero digits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module smg_scan_counter #(
    parameter int DIGITS  = 4,
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int SCAN_HZ = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [7:0]            sm_dat,
    output logic [DIGITS-1:0]     sm_sel,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  led
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = $clog2(DIGITS);

    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_DIV / 2 - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);

    logic [TICK_W-1:0]   r_tick_cnt;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_scan_on;
    logic                r_led;
    logic [4*DIGITS-1:0] r_count;
    logic                r_carry;
    logic [DIGITS-1:0]   r_sel;
    logic [7:0]          r_dat;

    logic                w_tick;
    logic                w_scan_adv;
    logic [4*DIGITS-1:0] w_load_clamped;
    logic [4*DIGITS-1:0] w_stepped;
    logic                w_rip;
    logic [3:0]          w_digit;
    logic                w_blank;
    logic [7:0]          w_seg;

    assign w_tick     = (r_tick_cnt == TICK_MAX);
    assign w_scan_adv = (r_scan_cnt == SCAN_MAX);

    // Segment pattern (active low, bit7 = a, bit0 = dp) for one BCD digit
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h03;
            4'd1:    seg7 = 8'h9F;
            4'd2:    seg7 = 8'h25;
            4'd3:    seg7 = 8'h0D;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h49;
            4'd6:    seg7 = 8'h41;
            4'd7:    seg7 = 8'h1F;
            4'd8:    seg7 = 8'h01;
            4'd9:    seg7 = 8'h09;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Out-of-range load nibbles saturate at 9 so the count stays valid BCD
    for (genvar g = 0; g < DIGITS; g++) begin : g_clamp
        assign w_load_clamped[4*g +: 4] =
            (load_val[4*g +: 4] > 4'd9) ? 4'd9 : load_val[4*g +: 4];
    end

    // Tick prescaler: free-running 0..TICK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end

    // Heartbeat toggles at mid-period and at the wrap of the tick prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_led <= 1'b0;
        else if (w_tick || r_tick_cnt == TICK_HALF) r_led <= ~r_led;
    end

    // Scan prescaler, digit index and "display live" flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_scan_on  <= 1'b0;
        end else if (w_scan_adv) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
            r_scan_on  <= 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Decimal +/-1 with ripple; w_rip left set means every digit wrapped
    always_comb begin
        w_stepped = r_count;
        w_rip     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_rip) begin
                if (up_dn) begin
                    if (r_count[4*i +: 4] == 4'd9) begin
                        w_stepped[4*i +: 4] = 4'd0;
                    end else begin
                        w_stepped[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        w_rip               = 1'b0;
                    end
                end else begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_stepped[4*i +: 4] = 4'd9;
                    end else begin
                        w_stepped[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        w_rip               = 1'b0;
                    end
                end
            end
        end
    end

    // Count register: clr > load > enabled tick > hold; carry only on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_carry <= 1'b0;
        end else if (en && w_tick) begin
            r_count <= w_stepped;
            r_carry <= w_rip;
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign w_digit = r_count[4*r_idx +: 4];

`ifdef SMG_ZERO_BLANK_EN
    logic [IDX_W-1:0] w_msnz;

    // Position of the most-significant nonzero digit (0 when count is zero)
    always_comb begin
        w_msnz = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_count[4*i +: 4] != 4'd0) w_msnz = IDX_W'(i);
        end
    end

    assign w_blank = (r_idx > w_msnz);
`else
    assign w_blank = 1'b0;
`endif

    // Segment code for the indexed digit with optional blanking and dp
    always_comb begin
        w_seg = w_blank ? 8'hFF : seg7(w_digit);
        if (dp_mask[r_idx]) w_seg[0] = 1'b0;
    end

    // Registered display outputs; kept dark until the first scan advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
            r_dat <= 8'hFF;
        end else if (r_scan_on) begin
            r_sel <= DIGITS'(1) << r_idx;
            r_dat <= w_seg;
        end
    end

    assign sm_dat = r_dat;
    assign sm_sel = r_sel;
    assign count  = r_count;
    assign carry  = r_carry;
    assign led    = r_led;

endmodule

`default_nettype wire

// File: tb/tb_smg_scan_counter.sv
// ============================================================================
//  Module   : tb_smg_scan_counter
//  Purpose  : Randomized + directed self-checking bench for smg_scan_counter
//             against a value-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_smg_scan_counter;

    localparam int DIGITS  = 4;
    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int SCAN_HZ = 50;
    localparam int TDIV    = CLK_HZ / TICK_HZ;
    localparam int SDIV    = CLK_HZ / SCAN_HZ;
    localparam int MOD     = 10 ** DIGITS;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en, clr, up_dn, load;
    logic [4*DIGITS-1:0] load_val;
    logic [DIGITS-1:0]   dp_mask;
    logic [7:0]          sm_dat;
    logic [DIGITS-1:0]   sm_sel;
    logic [4*DIGITS-1:0] count;
    logic                carry;
    logic                led;

    smg_scan_counter #(
        .DIGITS  (DIGITS),
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .dp_mask  (dp_mask),
        .sm_dat   (sm_dat),
        .sm_sel   (sm_sel),
        .count    (count),
        .carry    (carry),
        .led      (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_carry  = 0;

    // Reference model: count as an integer, k = clock edges since reset release
    int m_val;
    int m_k;
    bit m_carry;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int digit_of(input int v, input int i);
        return (v / (10 ** i)) % 10;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] b;
        for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'(digit_of(v, i));
        return b;
    endfunction

    function automatic int clamp_val(input logic [4*DIGITS-1:0] lv);
        int v;
        int n;
        v = 0;
        for (int i = 0; i < DIGITS; i++) begin
            n = int'(lv[4*i +: 4]);
            v += ((n > 9) ? 9 : n) * (10 ** i);
        end
        return v;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
        return tbl[d];
    endfunction

    // One clock: predict from pre-edge model state, advance, then compare
    task automatic step();
        int                idx;
        int                msd;
        int                toggles;
        logic [7:0]        e_dat;
        logic [DIGITS-1:0] e_sel;
        bit                tick;
        @(posedge clk);
        idx = (m_k / SDIV) % DIGITS;
        if (m_k >= SDIV) begin
            e_sel = DIGITS'(1) << idx;
            e_dat = seg_of(digit_of(m_val, idx));
`ifdef SMG_ZERO_BLANK_EN
            msd = 0;
            for (int i = 1; i < DIGITS; i++) if (digit_of(m_val, i) != 0) msd = i;
            if (idx > msd) e_dat = 8'hFF;
`else
            msd = 0;
`endif
            if (dp_mask[idx]) e_dat[0] = 1'b0;
        end else begin
            e_sel = '0;
            e_dat = 8'hFF;
            msd   = 0;
        end
        tick = ((m_k % TDIV) == TDIV - 1);
        if (clr) begin
            m_val = 0; m_carry = 0;
        end else if (load) begin
            m_val = clamp_val(load_val); m_carry = 0;
        end else if (en && tick) begin
            if (up_dn) begin
                m_carry = (m_val == MOD - 1);
                m_val   = (m_val + 1) % MOD;
            end else begin
                m_carry = (m_val == 0);
                m_val   = (m_val + MOD - 1) % MOD;
            end
        end else begin
            m_carry = 0;
        end
        toggles = ((m_k + 1) / TDIV) * 2 + ((((m_k + 1) % TDIV) >= TDIV / 2) ? 1 : 0);
        m_k++;
        #1;
        if (carry === 1'b1) n_carry++;
        check("count",  32'(count),  32'(to_bcd(m_val)));
        check("carry",  32'(carry),  32'(m_carry));
        check("sm_sel", 32'(sm_sel), 32'(e_sel));
        check("sm_dat", 32'(sm_dat), 32'(e_dat));
        check("led",    32'(led),    32'(toggles % 2));
    endtask

    // Assert reset away from an edge, verify immediate blanking, release on negedge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_count",  32'(count),  32'h0);
        check("rst_carry",  32'(carry),  32'h0);
        check("rst_led",    32'(led),    32'h0);
        check("rst_sm_sel", 32'(sm_sel), 32'h0);
        check("rst_sm_dat", 32'(sm_dat), 32'hFF);
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_val   = 0;
        m_k     = 0;
        m_carry = 0;
    endtask

    task automatic wait_sel(input logic [DIGITS-1:0] want, output bit ok);
        ok = 0;
        for (int i = 0; i < 4 * DIGITS * SDIV; i++) begin
            step();
            if (sm_sel === want) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        rst_n = 1'b1; en = 0; clr = 0; up_dn = 1; load = 0; load_val = '0; dp_mask = '0;
        m_val = 0; m_k = 0; m_carry = 0;
        #2;
        do_reset();

        // Ten ticks up from reset
        en = 1; up_dn = 1;
        n_carry = 0;
        repeat (10 * TDIV) step();
        check("up10_count", 32'(count), 32'h0010);
        check("up10_carry_pulses", 32'(n_carry), 32'd0);
        en = 0;
        wait_sel(4'b0010, ok);
        check("up10_sel_found", 32'(ok), 32'd1);
        check("up10_digit1", 32'(sm_dat), 32'h9F);

        // Up wrap from all nines
        load = 1; load_val = 16'h9999; step(); load = 0;
        check("load_9999", 32'(count), 32'h9999);
        en = 1; up_dn = 1; n_carry = 0;
        repeat (TDIV) step();
        check("wrap_up_count", 32'(count), 32'h0000);
        check("wrap_up_pulses", 32'(n_carry), 32'd1);

        // Down wrap from zero
        en = 0; load = 1; load_val = 16'h0000; step(); load = 0;
        en = 1; up_dn = 0; n_carry = 0;
        repeat (TDIV) step();
        check("wrap_dn_count", 32'(count), 32'h9999);
        check("wrap_dn_pulses", 32'(n_carry), 32'd1);

        // clr beats load; load clamps
        en = 0; clr = 1; load = 1; load_val = 16'h1234; step(); clr = 0; load = 0;
        check("clr_over_load", 32'(count), 32'h0000);
        load = 1; load_val = 16'h12AF; step(); load = 0;
        check("load_clamp", 32'(count), 32'h1299);

        // Decimal point on digit 1 with zero count
        dp_mask = 4'b0010; clr = 1; step(); clr = 0;
        step();
        wait_sel(4'b0010, ok);
        check("dp_sel_found", 32'(ok), 32'd1);
`ifdef SMG_ZERO_BLANK_EN
        check("dp_digit1", 32'(sm_dat), 32'hFE);
`else
        check("dp_digit1", 32'(sm_dat), 32'h02);
`endif
        dp_mask = '0;

        // Mid-count reset
        load = 1; load_val = 16'h0042; step(); load = 0;
        check("pre_reset_count", 32'(count), 32'h0042);
        do_reset();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            en       = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = 16'($urandom);
            if ($urandom_range(0, 29) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 399) == 0) do_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/smg_scan_counter.md
SMG_SCAN_COUNTER -- requirements
Module: smg_scan_counter

Interface
REQ-001 The block SHALL expose parameter DIGITS, default 4, meaning the number of multiplexed digits (range 2..8).
REQ-002 The block SHALL expose parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-003 The block SHALL expose parameter TICK_HZ, default 1, meaning the count-tick rate in Hz.
REQ-004 The block SHALL expose parameter SCAN_HZ, default 1000, meaning the per-digit advance rate in Hz.
REQ-005 The block SHALL have port clk, input, 1, system clock.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port en, input, 1, count enable.
REQ-008 The block SHALL have port clr, input, 1, synchronous clear.
REQ-009 The block SHALL have port up_dn, input, 1, count direction (1 = up, 0 = down).
REQ-010 The block SHALL have port load, input, 1, synchronous load strobe.
REQ-011 The block SHALL have port load_val, input, 4*DIGITS, BCD load value.
REQ-012 The block SHALL have port dp_mask, input, DIGITS, decimal-point enable per digit.
REQ-013 The block SHALL have port sm_dat, output, 8, active-low segments {a,b,c,d,e,f,g,dp}, with bit7 = a.
REQ-014 The block SHALL have port sm_sel, output, DIGITS, active-high one-hot digit select.
REQ-015 The block SHALL have port count, output, 4*DIGITS, current BCD count, digit 0 in bits [3:0].
REQ-016 The block SHALL have port carry, output, 1, one-cycle wrap pulse.
REQ-017 The block SHALL have port led, output, 1, heartbeat.

Function
REQ-018 The tick prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and wrap; tick is asserted for the single cycle at the maximum value.
REQ-019 Per-cycle count-update priority SHALL be: clr (count becomes 0) > load > en&&tick (count steps by one) > hold.
REQ-020 On load, each nibble of load_val SHALL be stored as-is if it is <=9 and clamped to 9 otherwise.
REQ-021 A step SHALL be decimal: an up step increments digit 0 and ripples a carry on each 9->0 transition; a down step decrements digit 0 and ripples a borrow on each 0->9 transition.
REQ-022 carry SHALL pulse high for exactly one cycle, concurrent with the count update, when an up step goes from all-9s to 0 or a down step goes from 0 to all-9s; clr and load SHALL never assert carry.
REQ-023 The scan prescaler SHALL count 0..CLK_HZ/SCAN_HZ-1; at its maximum value the digit index SHALL advance by one, wrapping DIGITS-1 -> 0.
REQ-024 sm_sel and sm_dat SHALL be registered, with one clk of latency from a digit-index or count change.
REQ-025 sm_sel SHALL be one-hot at bit index; sm_dat SHALL be the segment code of the indexed digit, with bit0 cleared when dp_mask[index] = 1.
REQ-026 The segment codes for digits 0..9 SHALL be, in hex: 03, 9F, 25, 0D, 99, 49, 41, 1F, 01, 09.
REQ-027 led SHALL toggle when the tick prescaler equals (CLK_HZ/TICK_HZ)/2-1 and again at its maximum value, giving two toggles per tick period.
REQ-028 Both prescalers and led SHALL run independently of en, clr and load.

Reset
REQ-029 While rst_n = 0, outputs SHALL be: count = 0, carry = 0, led = 0, sm_sel = all zero, sm_dat = 8'hFF; prescalers and digit index SHALL be 0.
REQ-030 Deassertion of reset SHALL take effect on the next clk edge; sm_sel SHALL stay all-zero until the first scan advance; assertion mid-operation SHALL blank the display immediately.

Configuration
REQ-031 With macro SMG_ZERO_BLANK_EN defined, digits above the most-significant nonzero digit SHALL output sm_dat = 8'hFF (dp still applied); digit 0 SHALL never be blanked.
REQ-032 Without SMG_ZERO_BLANK_EN, every digit SHALL display its value, including leading zeros.

Verification (DIGITS=4, CLK_HZ=100, TICK_HZ=10, SCAN_HZ=50: 10 clk/tick, 2 clk/digit)
REQ-033 Reset, en=1, up_dn=1 for 10 ticks -> count = 16'h0010, carry never asserted, digit 1 shows 8'h9F.
REQ-034 load 16'h9999, en=1, up_dn=1, one tick -> count = 16'h0000, carry high for exactly 1 cycle; the same test down from 16'h0000 -> 16'h9999 with a carry pulse.
REQ-035 clr and load asserted in the same cycle -> count = 0; load 16'h12AF alone -> count = 16'h1299.
REQ-036 Free-running scan -> sm_sel sequence 0001, 0010, 0100, 1000, 0001, each held for 2 cycles; dp_mask = 4'b0010 and count 16'h0000 -> digit 1 sm_dat = 8'h02.
REQ-037 With SMG_ZERO_BLANK_EN and count = 16'h0007 -> digits 3..1 show 8'hFF and digit 0 shows 8'h1F; with count = 16'h0000 -> digit 0 shows 8'h03.
REQ-038 rst_n pulsed low mid-count at 16'h0042 -> count = 0, sm_sel = 0, sm_dat = 8'hFF, led = 0 within the reset cycle.
